memory_unit: RTL and testbench
==============================

# memory_unit

Single-port 256 x 16 word memory that acts as the responder for the CPU's MAR/MBR memory interface. It accepts one read or write request at a time, with the address from MAR and the write data from MBR. After a programmable number of wait states it performs the access and returns read data on the data bus that MBR loads from. It also exposes a load port so the test harness or loader can preload program and data words while the memory is idle.

## Interface

Parameters:
- WAIT_CYCLES, default 2: extra wait states per access, 0..15.
- ADDR_WIDTH, default 8: address width (depth = 2^ADDR_WIDTH).
- DATA_WIDTH, default 16: word width.

Ports:
- i_clk, input, 1: clock; all state changes on the rising edge.
- i_rst, input, 1: reset, asynchronous and active-high.
- i_mar_addr, input, ADDR_WIDTH: access address, driven from MAR.
- i_mbr_data, input, DATA_WIDTH: write data, driven from MBR.
- i_rd_req, input, 1: read request; sampled only while o_ready=1.
- i_wr_req, input, 1: write request; sampled only while o_ready=1.
- i_load_we, input, 1: preload write enable.
- i_load_addr, input, ADDR_WIDTH: preload address.
- i_load_data, input, DATA_WIDTH: preload data.
- o_data_bus, output, DATA_WIDTH: registered read data, fed to MBR's data-bus input.
- o_ready, output, 1: high in IDLE; a request can be accepted.
- o_done, output, 1: one-cycle pulse when an access completes.
- o_err, output, 1: one-cycle pulse when a request is rejected.

## Operation

- FSM has three states: IDLE, BUSY and DONE. o_ready = (state == IDLE), decoded combinationally.
- **IDLE, exactly one of i_rd_req/i_wr_req high at an edge:**
  - latch address, write data and op;
  - counter <= WAIT_CYCLES;
  - go to BUSY.
- **IDLE, both requests high:**
  - no access;
  - o_err <= 1 for one cycle;
  - stay in IDLE.
- **BUSY:**
  - counter != 0: decrement.
  - counter == 0: perform the access and go to DONE.
    - Read: o_data_bus <= mem[latched addr].
    - Write: mem[latched addr] <= latched data.
- **DONE:** o_done = 1 (registered); go to IDLE at the next edge.
- Requests arriving in BUSY or DONE are ignored and not queued. The requester must hold or re-issue the request after o_ready returns.
- Address and data are taken from the latch. Changes on i_mar_addr or i_mbr_data after acceptance have no effect.
- o_data_bus holds the last read value. Writes, rejected requests and preloads never change it.
- Preload port:
  - honoured only in IDLE: mem[i_load_addr] <= i_load_data at the edge;
  - ignored in BUSY and DONE.
  - Preload and request at the same IDLE edge: both take effect. The later access observes the preloaded word.
- Counter width is 4 bits. WAIT_CYCLES above 15 is out of range (tool assertion).

## Timing

- Reset values: state IDLE, counter 0, o_data_bus 0, o_done 0, o_err 0, o_ready 1. Memory array contents are not cleared by reset.
- Request accepted at edge E0 (N = WAIT_CYCLES):
  - BUSY spans edges E1..EN, decrementing the counter.
  - Access is performed at E(N+1), with read data visible on o_data_bus just after E(N+1).
  - o_done is high between E(N+1) and E(N+2).
  - o_ready returns high after E(N+2).
- Per-access cost:
  - request-to-done latency is N+1 cycles;
  - back-to-back requests are spaced N+3 cycles apart.
- WAIT_CYCLES = 0: access at E1, o_done during E1..E2, ready again after E2.
- o_err rises after the rejecting edge and lasts exactly one cycle. o_ready stays high throughout.
- Reset asserted mid-access: the access is aborted at once and all outputs go to reset values.
  - A pending write is not performed; the addressed word keeps its old value.
  - A pending read leaves o_data_bus at 0.
- After reset deasserts, the first request can be accepted at the first rising edge.

## Test plan

- Reset, then preload mem[0x10] = 0xBEEF via the load port; read 0x10 with WAIT_CYCLES = 2 -> o_done high exactly 3 cycles after acceptance, o_data_bus = 0xBEEF, o_ready low for 4 cycles.
- Write 0x1234 to 0x20, change i_mbr_data to 0xFFFF one cycle after acceptance, then read 0x20 -> o_data_bus = 0x1234; o_data_bus unchanged (still the previous read value) during the write.
- Assert i_rd_req and i_wr_req together in IDLE -> o_err pulses 1 cycle, o_ready stays 1, no o_done, memory and o_data_bus unchanged.
- Issue a read at 0x30, then pulse i_wr_req and i_load_we while BUSY -> both ignored: single o_done for the read, mem[0x30] unchanged.
- Start a write of 0x5555 to 0x40 (old value 0xAAAA), assert i_rst one cycle after acceptance -> outputs go to reset values, o_done never pulses, a subsequent read of 0x40 returns 0xAAAA.
- WAIT_CYCLES = 0 build: back-to-back reads of 0x00 and 0x01 -> o_done pulses 3 cycles apart, each 1 cycle after its acceptance edge.

Source files
------------

// File: rtl/memory_unit.sv
// 256x16 single-port memory responder for the MAR/MBR interface; access completes WAIT_CYCLES+1 cycles after acceptance.
// One request at a time: o_ready is low from acceptance until the cycle after o_done, and requests seen while busy are dropped.
module memory_unit #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_mar_addr,
  input  logic [DATA_WIDTH-1:0] i_mbr_data,
  input  logic                  i_rd_req,
  input  logic                  i_wr_req,
  input  logic                  i_load_we,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
      $error("memory_unit: WAIT_CYCLES must be within 0..15");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  op_wr_q;
  logic [DATA_WIDTH-1:0] data_bus_q;
  logic                  done_q;
  logic                  err_q;

  logic                  access_d;
  logic                  mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_waddr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d;

  assign access_d = (state_q == S_BUSY) && (cnt_q == 4'd0);

  // Reset gates the array write so an aborted access never lands in memory.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = i_load_addr;
    mem_wdata_d = i_load_data;
    if (!i_rst) begin
      if (state_q == S_IDLE && i_load_we) begin
        mem_we_d = 1'b1;
      end else if (access_d && op_wr_q) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = addr_q;
        mem_wdata_d = wdata_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we_d) begin
      mem_q[mem_waddr_d] <= mem_wdata_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_wr_q    <= 1'b0;
      data_bus_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_rd_req && i_wr_req) begin
            err_q <= 1'b1;
          end else if (i_rd_req || i_wr_req) begin
            addr_q  <= i_mar_addr;
            wdata_q <= i_mbr_data;
            op_wr_q <= i_wr_req;
            cnt_q   <= WAIT_INIT;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!op_wr_q) begin
              data_bus_q <= mem_q[addr_q];
            end
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign o_data_bus = data_bus_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance share one clock.
// Expected o_data_bus values are queued when a request is driven and popped when o_done is seen.
module tb_memory_unit;

  localparam int WA = 2;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rd_a, wr_a, ld_we_a;
  logic [7:0]  mar_a, ld_addr_a;
  logic [15:0] mbr_a, ld_dat_a, data_a;
  logic        ready_a, done_a, err_a;

  logic        rst_b, rd_b, wr_b, ld_we_b;
  logic [7:0]  mar_b, ld_addr_b;
  logic [15:0] mbr_b, ld_dat_b, data_b;
  logic        ready_b, done_b, err_b;

  memory_unit #(.WAIT_CYCLES(WA), .ADDR_WIDTH(8), .DATA_WIDTH(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_mar_addr(mar_a), .i_mbr_data(mbr_a),
    .i_rd_req(rd_a), .i_wr_req(wr_a), .i_load_we(ld_we_a),
    .i_load_addr(ld_addr_a), .i_load_data(ld_dat_a),
    .o_data_bus(data_a), .o_ready(ready_a), .o_done(done_a), .o_err(err_a)
  );

  memory_unit #(.WAIT_CYCLES(0), .ADDR_WIDTH(8), .DATA_WIDTH(16)) u_dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_mar_addr(mar_b), .i_mbr_data(mbr_b),
    .i_rd_req(rd_b), .i_wr_req(wr_b), .i_load_we(ld_we_b),
    .i_load_addr(ld_addr_b), .i_load_data(ld_dat_b),
    .o_data_bus(data_b), .o_ready(ready_b), .o_done(done_b), .o_err(err_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mdl [256];
  logic [15:0] lr_a;
  logic [15:0] sb_a [$];
  logic [15:0] sb_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_a(input logic [7:0] addr, input logic [15:0] dat);
    ld_we_a = 1'b1; ld_addr_a = addr; ld_dat_a = dat;
    mdl[addr] = dat;
    step();
    ld_we_a = 1'b0;
  endtask

  // One full access on DUT A; after acceptance MAR/MBR are scrambled, and with poke a
  // write request plus a preload are driven into the BUSY window to show they are dropped.
  task automatic acc_a(input bit wr, input logic [7:0] addr, input logic [15:0] wd, input bit poke);
    int lat;
    int lows;
    mar_a = addr; mbr_a = wd;
    if (wr) begin
      wr_a = 1'b1; mdl[addr] = wd;
    end else begin
      rd_a = 1'b1; lr_a = mdl[addr];
    end
    sb_a.push_back(lr_a);
    step();
    rd_a = 1'b0; wr_a = 1'b0; mar_a = ~addr; mbr_a = 16'hFFFF;
    if (poke) begin
      wr_a = 1'b1; ld_we_a = 1'b1; ld_addr_a = addr; ld_dat_a = 16'hDEAD;
    end
    lows = ready_a ? 0 : 1;
    lat  = 0;
    while (!done_a && lat < 40) begin
      step();
      wr_a = 1'b0; ld_we_a = 1'b0;
      lat++;
      if (!ready_a) lows++;
    end
    chk("latency", lat, WA + 1);
    chk("ready_low_cycles", lows, WA + 2);
    if (sb_a.size() > 0) chk("data_bus_at_done", data_a, sb_a.pop_front());
    step();
    chk("ready_back", ready_a, 1);
    chk("single_done", done_a, 0);
  endtask

  initial begin
    int ndone;
    int t1;
    int t2;
    rst_a = 1'b1; rd_a = 1'b0; wr_a = 1'b0; ld_we_a = 1'b0;
    mar_a = '0; mbr_a = '0; ld_addr_a = '0; ld_dat_a = '0;
    rst_b = 1'b1; rd_b = 1'b0; wr_b = 1'b0; ld_we_b = 1'b0;
    mar_b = '0; mbr_b = '0; ld_addr_b = '0; ld_dat_b = '0;
    lr_a = '0;
    repeat (2) step();
    chk("rst_data_bus", data_a, 0);
    chk("rst_ready", ready_a, 1);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Preload then read back with two wait states.
    preload_a(8'h10, 16'hBEEF);
    acc_a(1'b0, 8'h10, 16'h0000, 1'b0);

    // Write with MBR disturbed after acceptance, then read it back.
    acc_a(1'b1, 8'h20, 16'h1234, 1'b0);
    acc_a(1'b0, 8'h20, 16'h0000, 1'b0);

    // Both requests at once in IDLE are rejected.
    rd_a = 1'b1; wr_a = 1'b1; mar_a = 8'h20; mbr_a = 16'h0BAD;
    step();
    rd_a = 1'b0; wr_a = 1'b0;
    chk("err_pulse", err_a, 1);
    chk("err_ready", ready_a, 1);
    chk("err_no_done", done_a, 0);
    step();
    chk("err_one_cycle", err_a, 0);
    chk("err_ready_after", ready_a, 1);
    chk("err_bus_kept", data_a, lr_a);
    acc_a(1'b0, 8'h20, 16'h0000, 1'b0);

    // Write request and preload during BUSY are dropped.
    preload_a(8'h30, 16'h3030);
    acc_a(1'b0, 8'h30, 16'h0000, 1'b1);
    acc_a(1'b0, 8'h30, 16'h0000, 1'b0);

    // Reset one cycle into a write aborts it.
    preload_a(8'h40, 16'hAAAA);
    wr_a = 1'b1; mar_a = 8'h40; mbr_a = 16'h5555;
    step();
    wr_a = 1'b0; mbr_a = 16'h0000;
    step();
    chk("abort_busy_before_rst", ready_a, 0);
    rst_a = 1'b1;
    #1;
    chk("abort_data_bus", data_a, 0);
    chk("abort_ready", ready_a, 1);
    chk("abort_done", done_a, 0);
    chk("abort_err", err_a, 0);
    repeat (2) begin
      step();
      chk("abort_no_done", done_a, 0);
    end
    rst_a = 1'b0;
    lr_a = 16'h0000;
    acc_a(1'b0, 8'h40, 16'h0000, 1'b0);

    // Zero-wait instance: back-to-back reads with the request held high.
    ld_we_b = 1'b1; ld_addr_b = 8'h00; ld_dat_b = 16'h0A0A;
    step();
    ld_addr_b = 8'h01; ld_dat_b = 16'h0B0B;
    step();
    ld_we_b = 1'b0;
    rd_b = 1'b1; mar_b = 8'h00;
    sb_b.push_back(16'h0A0A);
    step();
    chk("b_accept", ready_b, 0);
    mar_b = 8'h01;
    sb_b.push_back(16'h0B0B);
    ndone = 0; t1 = 0; t2 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (done_b) begin
        ndone++;
        if (ndone == 1) t1 = k;
        else if (ndone == 2) begin
          t2 = k;
          rd_b = 1'b0;
        end
        if (sb_b.size() > 0) chk("b_data_bus", data_b, sb_b.pop_front());
      end
    end
    chk("b_first_done_cycle", t1, 1);
    chk("b_done_spacing", t2 - t1, 3);
    chk("b_done_count", ndone, 2);
    chk("b_no_err", err_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
